// File: rtl/main_mem_port_if.sv
// main_mem_port_if: every signal between one core-side memory port and
// its environment: the core command side and this core's slice of the
// shared main-memory arbiter.
//
// Modports
//   master : the port itself (main_mem_port). It drives the arbiter
//            requests, strobes, address/data and the core status.
//   slave  : the environment (core + arbiter). It drives the core
//            command, the grant bits and the shared read-data bus.
//
// Signals
//   cpu_req_valid/op/adr/wdat : core command (op 00 rd, 01 wr, 10 lock, 11 unlock)
//   cpu_busy, cpu_done, cpu_rdat : command status and read data back to the core
//   main_mem_*               : arbiter request/strobe/address/data, grant, read bus
//   lock_adr, lock_en, unlock_en, lock_ac : mutex request and its grant
//   dbg_state                : current FSM state, for observation only
interface main_mem_port_if;
   logic        cpu_req_valid;
   logic [1:0]  cpu_req_op;
   logic [15:0] cpu_adr;
   logic [15:0] cpu_wdat;
   logic        cpu_busy;
   logic        cpu_done;
   logic [15:0] cpu_rdat;

   logic        main_mem_write_request;
   logic        main_mem_read_request;
   logic        main_mem_write;
   logic        main_mem_read;
   logic [15:0] main_mem_write_adr;
   logic [15:0] main_mem_write_dat;
   logic        main_mem_ac;
   logic [15:0] main_mem_dat;

   logic [9:0]  lock_adr;
   logic        lock_en;
   logic        unlock_en;
   logic        lock_ac;

   logic [2:0]  dbg_state;

   modport master (
      input  cpu_req_valid, cpu_req_op, cpu_adr, cpu_wdat,
      input  main_mem_ac, main_mem_dat, lock_ac,
      output cpu_busy, cpu_done, cpu_rdat,
      output main_mem_write_request, main_mem_read_request,
      output main_mem_write, main_mem_read,
      output main_mem_write_adr, main_mem_write_dat,
      output lock_adr, lock_en, unlock_en,
      output dbg_state
   );

   modport slave (
      output cpu_req_valid, cpu_req_op, cpu_adr, cpu_wdat,
      output main_mem_ac, main_mem_dat, lock_ac,
      input  cpu_busy, cpu_done, cpu_rdat,
      input  main_mem_write_request, main_mem_read_request,
      input  main_mem_write, main_mem_read,
      input  main_mem_write_adr, main_mem_write_dat,
      input  lock_adr, lock_en, unlock_en,
      input  dbg_state
   );
endinterface

// File: rtl/main_mem_port.sv
// main_mem_port: core-side initiator for the shared main-memory arbiter.
// Turns one core command (read, write, lock, unlock) into the arbiter's
// request / strobe / lock handshake and reports completion to the core.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous reset, active low (0 = in reset)
//   bus        : main_mem_port_if.master (core command side + arbiter side)
//   stall_cnt  : [15:0] cycles spent requesting with the grant low
//                (present only when MAIN_MEM_PORT_STALL_CNT_EN is defined)
//
// Handshake: a command is taken on a rising edge where cpu_req_valid=1
// and cpu_busy=0; valid while busy is dropped, never queued. An arbiter
// request stays high until this core's grant bit is seen high in the
// same cycle; the strobe is request AND grant, so it is high only in the
// grant cycle. cpu_done is a one-cycle registered pulse in an IDLE
// cycle, so the next command can be taken in that same cycle.
//
// Optional feature macro: MAIN_MEM_PORT_STALL_CNT_EN (saturating stall counter).
module main_mem_port #(
   parameter int ID = 0
) (
   input  logic                clk,
   input  logic                reset,
   main_mem_port_if.master     bus
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   // ID only selects which arbiter bit this instance is wired to.
   if (ID < 0 || ID > 7) begin : g_id_range
      $error("main_mem_port: ID must be in 0..7");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      RD_REQ = 3'd2,
      RD_CAP = 3'd3,
      LK_REQ = 3'd4,
      UL_REQ = 3'd5
   } state_t;

   state_t      r_state;
   logic        r_done;
   logic [15:0] r_rdat;
   logic        r_wr_req;
   logic        r_rd_req;
   logic [15:0] r_adr;
   logic [15:0] r_wdat;
   logic [9:0]  r_lock_adr;
   logic        r_lock_en;
   logic        r_unlock_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_done      <= 1'b0;
         r_rdat      <= 16'h0000;
         r_wr_req    <= 1'b0;
         r_rd_req    <= 1'b0;
         r_adr       <= 16'h0000;
         r_wdat      <= 16'h0000;
         r_lock_adr  <= 10'h000;
         r_lock_en   <= 1'b0;
         r_unlock_en <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.cpu_req_valid) begin
                  r_adr      <= bus.cpu_adr;
                  r_lock_adr <= bus.cpu_adr[9:0];
                  r_wdat     <= bus.cpu_wdat;
                  case (bus.cpu_req_op)
                     2'b00: begin
                        r_state  <= RD_REQ;
                        r_rd_req <= 1'b1;
                     end
                     2'b01: begin
                        r_state  <= WR_REQ;
                        r_wr_req <= 1'b1;
                     end
                     2'b10: begin
                        r_state   <= LK_REQ;
                        r_lock_en <= 1'b1;
                     end
                     default: begin
                        r_state     <= UL_REQ;
                        r_unlock_en <= 1'b1;
                     end
                  endcase
               end
            end
            WR_REQ: begin
               if (bus.main_mem_ac) begin
                  r_wr_req <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= IDLE;
               end
            end
            RD_REQ: begin
               if (bus.main_mem_ac) begin
                  r_rd_req <= 1'b0;
                  r_state  <= RD_CAP;
               end
            end
            RD_CAP: begin
               // Shared bus carries our data the cycle after the read strobe.
               r_rdat  <= bus.main_mem_dat;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            LK_REQ: begin
               if (bus.lock_ac) begin
                  r_lock_en <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            UL_REQ: begin
               if (bus.lock_ac) begin
                  r_unlock_en <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_wr_req    <= 1'b0;
               r_rd_req    <= 1'b0;
               r_lock_en   <= 1'b0;
               r_unlock_en <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_busy               = (r_state != IDLE);
   assign bus.cpu_done               = r_done;
   assign bus.cpu_rdat               = r_rdat;
   assign bus.main_mem_write_request = r_wr_req;
   assign bus.main_mem_read_request  = r_rd_req;
   // Grant is combinational from the arbiter, so the strobe lands in the grant cycle.
   assign bus.main_mem_write         = r_wr_req & bus.main_mem_ac;
   assign bus.main_mem_read          = r_rd_req & bus.main_mem_ac;
   assign bus.main_mem_write_adr     = r_adr;
   assign bus.main_mem_write_dat     = r_wdat;
   assign bus.lock_adr               = r_lock_adr;
   assign bus.lock_en                = r_lock_en;
   assign bus.unlock_en              = r_unlock_en;
   assign bus.dbg_state              = r_state;

`ifdef MAIN_MEM_PORT_STALL_CNT_EN
   logic        w_stall;
   logic [15:0] r_stall_cnt;

   always_comb begin
      w_stall = 1'b0;
      if ((r_state == WR_REQ) || (r_state == RD_REQ))
         w_stall = !bus.main_mem_ac;
      else if ((r_state == LK_REQ) || (r_state == UL_REQ))
         w_stall = !bus.lock_ac;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= 16'h0000;
      else if (w_stall && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'h0001;
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_main_mem_port.sv
`timescale 1ns/1ps
module tb_main_mem_port;

   localparam int DUT_ID   = 3;
   localparam int CLK_HALF = 5;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;

   main_mem_port_if bus();

`ifdef MAIN_MEM_PORT_STALL_CNT_EN
   logic [15:0] stall_cnt;
   int          exp_stall = 0;
`endif

   main_mem_port #(.ID(DUT_ID)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #CLK_HALF clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic [1:0]  op;
      logic [15:0] adr;
      logic [15:0] wdat;
      logic [15:0] rdat;
      logic [7:0]  dly;
      logic [31:0] done_cyc;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   int               delay_q[$];
   int               checks = 0;
   int               errors = 0;

   // Reference memory (model) and the arbiter-side memory (environment).
   logic [15:0] ref_mem [256];
   logic [15:0] arb_mem [256];

   // Arbiter grant vectors; this core sees bit DUT_ID.
   logic [7:0] mem_ac_vec;
   logic [7:0] lock_ac_vec;
   assign bus.main_mem_ac = mem_ac_vec[DUT_ID];
   assign bus.lock_ac     = lock_ac_vec[DUT_ID];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- driver ----------------
   task automatic issue(input logic [1:0] op, input logic [15:0] adr,
                        input logic [15:0] wdat, input int dly, input bit wait_done);
      exp_t e;
      int   guard;
      guard = 0;
      while (bus.cpu_busy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (bus.cpu_busy) begin
         check("issue_wait_idle", 32'(bus.cpu_busy), 32'd0);
         return;
      end
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_op    = op;
      bus.cpu_adr       = adr;
      bus.cpu_wdat      = wdat;
      e.op   = op;
      e.adr  = adr;
      e.wdat = wdat;
      e.rdat = (op == 2'b00) ? ref_mem[adr[7:0]] : 16'h0000;
      if (op == 2'b01) ref_mem[adr[7:0]] = wdat;
      e.dly  = 8'(dly);
      // This cycle is cycle 0; its closing edge accepts the command.
      e.done_cyc = 32'(cyc + ((op == 2'b00) ? 3 : 2) + dly);
      exp_q.push_back(e);
      delay_q.push_back(dly);
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
      exp_stall += dly;
`endif
      @(negedge clk);
      check("busy_after_accept", 32'(bus.cpu_busy), 32'd1);
      if (!wait_done) begin
         bus.cpu_req_valid = 1'b0;
         return;
      end
      guard = 0;
      while (bus.cpu_busy && guard < 500) begin
         // Junk commands while busy must be ignored.
         bus.cpu_req_valid = 1'($urandom_range(0, 1));
         bus.cpu_req_op    = 2'($urandom);
         bus.cpu_adr       = 16'($urandom);
         bus.cpu_wdat      = 16'($urandom);
         @(negedge clk);
         guard++;
      end
      bus.cpu_req_valid = 1'b0;
      if (bus.cpu_busy) check("done_timeout", 32'(bus.cpu_busy), 32'd0);
   endtask

   // ---------------- arbiter / memory responder ----------------
   bit         active;
   int         wcnt;
   int         cur_dly;
   bit         rd_pending;
   logic [7:0] rd_adr;

   initial begin
      logic mem_req, lk_req, grant;
      mem_ac_vec       = 8'h00;
      lock_ac_vec      = 8'h00;
      bus.main_mem_dat = 16'h0000;
      active = 0; rd_pending = 0; wcnt = 0; cur_dly = 0; rd_adr = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset) begin
            active      = 0;
            rd_pending  = 0;
            mem_ac_vec  = 8'h00;
            lock_ac_vec = 8'h00;
            delay_q.delete();
         end else begin
            bus.main_mem_dat = rd_pending ? arb_mem[rd_adr] : 16'($urandom);
            rd_pending  = 0;
            // Grant noise everywhere the port is not waiting on that grant.
            mem_ac_vec  = 8'($urandom);
            lock_ac_vec = 8'($urandom);
            mem_req = bus.main_mem_write_request | bus.main_mem_read_request;
            lk_req  = bus.lock_en | bus.unlock_en;
            if (!(mem_req || lk_req)) begin
               active = 0;
            end else begin
               if (!active) begin
                  active  = 1;
                  wcnt    = 0;
                  cur_dly = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
               end
               grant = (wcnt == cur_dly);
               wcnt++;
               if (mem_req) mem_ac_vec[DUT_ID]  = grant;
               else         lock_ac_vec[DUT_ID] = grant;
               if (grant) begin
                  active = 0;
                  if (bus.main_mem_read_request) begin
                     rd_pending = 1;
                     rd_adr     = bus.main_mem_write_adr[7:0];
                  end
                  if (bus.main_mem_write_request)
                     arb_mem[bus.main_mem_write_adr[7:0]] = bus.main_mem_write_dat;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      int          req_cyc;
      int          strobe_cnt;
      logic [15:0] exp_rdat_hold;
      logic        rq;
      exp_t        e;
      req_cyc = 0; strobe_cnt = 0; exp_rdat_hold = 16'h0000;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            req_cyc = 0; strobe_cnt = 0; exp_rdat_hold = 16'h0000;
            continue;
         end
         check("req_exclusive",
               32'($countones({bus.main_mem_read_request, bus.main_mem_write_request,
                               bus.lock_en, bus.unlock_en}) <= 1), 32'd1);
         check("wr_strobe_rule", 32'(bus.main_mem_write),
               32'(bus.main_mem_write_request & bus.main_mem_ac));
         check("rd_strobe_rule", 32'(bus.main_mem_read),
               32'(bus.main_mem_read_request & bus.main_mem_ac));
         if (exp_q.size() > 0) begin
            e = exp_t'(exp_q[0]);
            case (e.op)
               2'b00:   rq = bus.main_mem_read_request;
               2'b01:   rq = bus.main_mem_write_request;
               2'b10:   rq = bus.lock_en;
               default: rq = bus.unlock_en;
            endcase
            if (rq) req_cyc++;
            if (bus.main_mem_write) begin
               strobe_cnt++;
               check("wr_strobe_op", 32'(e.op), 32'd1);
               check("wr_adr", 32'(bus.main_mem_write_adr), 32'(e.adr));
               check("wr_dat", 32'(bus.main_mem_write_dat), 32'(e.wdat));
            end
            if (bus.main_mem_read) begin
               strobe_cnt++;
               check("rd_strobe_op", 32'(e.op), 32'd0);
               check("rd_adr", 32'(bus.main_mem_write_adr), 32'(e.adr));
            end
            if (bus.lock_en || bus.unlock_en)
               check("lock_adr", 32'(bus.lock_adr), 32'(e.adr[9:0]));
            if (bus.cpu_done) begin
               void'(exp_q.pop_front());
               check("done_cycle", 32'(cyc), e.done_cyc);
               check("req_cycles", 32'(req_cyc), 32'(e.dly) + 32'd1);
               check("strobe_count", 32'(strobe_cnt), (e.op < 2'b10) ? 32'd1 : 32'd0);
               if (e.op == 2'b00) begin
                  check("rd_data", 32'(bus.cpu_rdat), 32'(e.rdat));
                  exp_rdat_hold = e.rdat;
               end
               req_cyc = 0;
               strobe_cnt = 0;
            end
         end else begin
            check("no_cmd_done", 32'(bus.cpu_done), 32'd0);
            check("no_cmd_req", 32'({bus.main_mem_read_request, bus.main_mem_write_request,
                                     bus.lock_en, bus.unlock_en}), 32'd0);
         end
         check("rdat_hold", 32'(bus.cpu_rdat), 32'(exp_rdat_hold));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0]  op;
      logic [15:0] adr;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 16'h0000;
         arb_mem[i] = 16'h0000;
      end
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_op    = 2'b00;
      bus.cpu_adr       = 16'h0000;
      bus.cpu_wdat      = 16'h0000;

      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(bus.cpu_busy), 32'd0);
      check("rst_done", 32'(bus.cpu_done), 32'd0);
      check("rst_rdat", 32'(bus.cpu_rdat), 32'd0);
      check("rst_wreq", 32'(bus.main_mem_write_request), 32'd0);
      check("rst_rreq", 32'(bus.main_mem_read_request), 32'd0);
      check("rst_adr", 32'(bus.main_mem_write_adr), 32'd0);
      check("rst_dat", 32'(bus.main_mem_write_dat), 32'd0);
      check("rst_lock_adr", 32'(bus.lock_adr), 32'd0);
      check("rst_lock_en", 32'(bus.lock_en), 32'd0);
      check("rst_unlock_en", 32'(bus.unlock_en), 32'd0);
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Directed sequence from the test plan.
      issue(2'b01, 16'h0040, 16'h1234, 0, 1);
      issue(2'b00, 16'h0040, 16'h0000, 3, 1);
      issue(2'b01, 16'h0041, 16'hBEEF, 0, 1);   // issued in the read's done cycle
      issue(2'b10, 16'h03FF, 16'h0000, 5, 1);
      issue(2'b11, 16'h03FF, 16'h0000, 0, 1);

      // Randomised traffic over a small address set so reads hit earlier writes.
      for (int n = 0; n < 40; n++) begin
         op  = 2'($urandom);
         adr = {8'($urandom), 5'd0, 3'($urandom_range(0, 7))};
         issue(op, adr, 16'($urandom), $urandom_range(0, 4), 1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
      check("stall_cnt_random", 32'(stall_cnt), 32'(exp_stall));
`endif

      // Reset in the middle of a read request.
      issue(2'b00, 16'h0040, 16'h0000, 0, 1);
      issue(2'b00, 16'h0040, 16'h0000, 20, 0);
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(bus.cpu_busy), 32'd0);
      check("arst_done", 32'(bus.cpu_done), 32'd0);
      check("arst_rdat", 32'(bus.cpu_rdat), 32'd0);
      check("arst_rreq", 32'(bus.main_mem_read_request), 32'd0);
      check("arst_rd_strobe", 32'(bus.main_mem_read), 32'd0);
      check("arst_adr", 32'(bus.main_mem_write_adr), 32'd0);
      check("arst_lock_adr", 32'(bus.lock_adr), 32'd0);
      exp_q.delete();
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
      exp_stall = 0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_busy", 32'(bus.cpu_busy), 32'd0);
      check("post_rst_rdat", 32'(bus.cpu_rdat), 32'd0);

      // Stall accounting: 3 stalled write cycles + 5 stalled lock cycles.
      issue(2'b01, 16'h0010, 16'h5555, 3, 1);
      issue(2'b10, 16'h0123, 16'h0000, 5, 1);
`ifdef MAIN_MEM_PORT_STALL_CNT_EN
      check("stall_cnt_8", 32'(stall_cnt), 32'd8);
`endif
      issue(2'b11, 16'h0123, 16'h0000, 0, 1);
      issue(2'b00, 16'h0010, 16'h0000, 1, 1);

      repeat (5) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/main_mem_port.md
Name: main_mem_port

Overview:
- Core-side initiator for the shared main-memory arbiter; one instance per core.
- Turns a single core-side command (read, write, lock, unlock) into the arbiter's request/strobe/lock handshake.
- Holds its request until its one-hot grant bit arrives, then returns read data or completion to the core.
- The arbiter-side outputs of instance ID are wired to bit/element ID of the arbiter's vectors.

Parameters:
- ID, 0, core index 0..7; informational only, and used by the bench to pick the grant bit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- cpu_req_valid  in  1  command strobe; sampled only when cpu_busy=0
- cpu_req_op  in  2  00 read, 01 write, 10 lock, 11 unlock
- cpu_adr  in  16  memory address; bits [9:0] are the lock index for lock/unlock
- cpu_wdat  in  16  write data
- cpu_busy  out  1  command in progress
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdat  out  16  read data, valid when cpu_done follows a read; held until the next read completes
- main_mem_write_request  out  1  write request to the arbiter
- main_mem_read_request  out  1  read request to the arbiter
- main_mem_write  out  1  write strobe
- main_mem_read  out  1  read strobe
- main_mem_write_adr  out  16  address for both reads and writes
- main_mem_write_dat  out  16  write data
- main_mem_ac  in  1  this core's grant bit (combinational from the arbiter)
- main_mem_dat  in  16  shared read data bus, valid the cycle after the read strobe
- lock_adr  out  10  mutex index
- lock_en  out  1  lock request
- unlock_en  out  1  unlock request
- lock_ac  in  1  this core's lock/unlock grant bit

Behaviour:
- States: IDLE, WR_REQ, RD_REQ, RD_CAP, LK_REQ, UL_REQ. cpu_busy = (state != IDLE).
- Reset (reset=0, asynchronous): state=IDLE; cpu_done=0; cpu_rdat=0; all request, strobe and enable outputs 0; address, data and lock_adr registers 0.
- IDLE + cpu_req_valid:
  - latch cpu_adr into main_mem_write_adr and cpu_adr[9:0] into lock_adr;
  - latch cpu_wdat into main_mem_write_dat;
  - go to RD_REQ, WR_REQ, LK_REQ or UL_REQ by op.
  - cpu_req_valid while busy is ignored and not queued.
- WR_REQ: main_mem_write_request=1.
  - main_mem_write = main_mem_write_request & main_mem_ac (combinational, same cycle as the grant).
  - On ac: IDLE next edge, cpu_done=1 for the following cycle. No ac: stay, request held.
- RD_REQ: main_mem_read_request=1; main_mem_read = request & ac.
  - On ac: go to RD_CAP.
- RD_CAP: no request or strobe driven.
  - Register main_mem_dat into cpu_rdat at the end of this cycle.
  - Go to IDLE; cpu_done=1 the next cycle.
- LK_REQ: lock_en=1 until lock_ac; then IDLE with cpu_done pulse. Waiting on a held mutex is unbounded.
- UL_REQ: unlock_en=1 until lock_ac; then IDLE with cpu_done pulse.
- Outputs that must never be 1 simultaneously: read_request, write_request, lock_en, unlock_en.
- Strobes never rise without ac in the same cycle.
- cpu_done is registered and lasts exactly 1 cycle. The cycle with cpu_done=1 is IDLE, so a new command may be accepted in that same cycle.
- Latency with no contention, counted from the accept edge:
  - write: done 2 cycles later;
  - read: done 3 cycles later with data;
  - lock/unlock: 2 cycles.
- ac seen in a state that does not match the current request (e.g. IDLE) is ignored.
- Reset mid-operation: the command is abandoned and no done pulse is produced. The arbiter's mutex table is cleared by the same system reset.

Optional Feature:
- Macro MAIN_MEM_PORT_STALL_CNT_EN.
- Defined:
  - adds output stall_cnt [15:0];
  - stall_cnt increments in every cycle spent in WR_REQ, RD_REQ, LK_REQ or UL_REQ with the grant low;
  - saturates at 16'hFFFF and is cleared only by reset.
- Not defined: port absent, no counter logic.

Test Plan:
- Write 0x1234 to adr 0x0040, ac returned immediately:
  - main_mem_write=1 for exactly 1 cycle, with adr 0x0040 and dat 0x1234;
  - cpu_done 2 cycles after accept.
- Read adr 0x0040 with ac withheld for 3 cycles, bench returns main_mem_dat=0x1234 the cycle after the strobe:
  - read_request held 4 cycles; main_mem_read=1 only in the grant cycle;
  - cpu_rdat=0x1234 with cpu_done 6 cycles after accept.
- Lock index 0x3FF, lock_ac held 0 for 5 cycles (mutex busy) and then 1:
  - lock_en high for 6 cycles, then cpu_done.
  - A following unlock with immediate lock_ac: unlock_en high 1 cycle, then done.
- Back-to-back: new write issued in the cpu_done cycle of the previous read:
  - accepted with no gap;
  - cpu_req_valid asserted while cpu_busy=1 has no effect.
- Reset asserted in RD_REQ, then released:
  - all outputs 0 immediately (asynchronous);
  - no cpu_done; state IDLE; cpu_rdat=0.
- With MAIN_MEM_PORT_STALL_CNT_EN: 3 stalled write cycles plus 5 stalled lock cycles give stall_cnt=8.
